// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, boot-vector load, two-word immediate fetch, stall and redirect into IF/ID
module fetch_stage #(
  parameter int PC_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] BOOT_ADDR = '0,
  parameter int IMM_FLAG_BIT = 26
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [PC_WIDTH-1:0]   pc_address,
  input  logic [INST_WIDTH-1:0] instruction,
  input  logic                  stall,
  input  logic                  redirect_en,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic [INST_WIDTH-1:0] ifid_instruction,
  output logic [INST_WIDTH-1:0] ifid_immediate,
  output logic [PC_WIDTH-1:0]   ifid_pc,
  output logic                  ifid_valid,
  output logic                  boot_done
);
  typedef enum logic [1:0] {BOOT, FETCH, IMM} state_t;
  state_t state, state_nx;
  logic [PC_WIDTH-1:0] pc, pc_nx, hold_pc, hold_pc_nx, ifid_pc_nx;
  logic [INST_WIDTH-1:0] hold_reg, hold_reg_nx, ifid_instruction_nx, ifid_immediate_nx;
  logic ifid_valid_nx, boot_done_nx, flag;
  assign pc_address = state == BOOT ? BOOT_ADDR : pc;
  assign flag = instruction[IMM_FLAG_BIT];
  always_comb begin
    state_nx = state;
    pc_nx = pc;
    hold_reg_nx = hold_reg;
    hold_pc_nx = hold_pc;
    ifid_instruction_nx = ifid_instruction;
    ifid_immediate_nx = ifid_immediate;
    ifid_pc_nx = ifid_pc;
    ifid_valid_nx = ifid_valid;
    boot_done_nx = boot_done;
    if (state == BOOT) begin
      pc_nx = PC_WIDTH'(instruction);
      boot_done_nx = 1'b1;
      ifid_valid_nx = 1'b0;
      state_nx = FETCH;
    end else if (redirect_en) begin
      // redirect wins over stall; a half-fetched two-word instruction is dropped
      pc_nx = redirect_pc;
      hold_reg_nx = '0;
      ifid_valid_nx = 1'b0;
      state_nx = FETCH;
    end else if (!stall) begin
      pc_nx = pc + 1'b1;
      if (state == IMM) begin
        ifid_instruction_nx = hold_reg;
        ifid_immediate_nx = instruction;
        ifid_pc_nx = hold_pc;
        ifid_valid_nx = 1'b1;
        state_nx = FETCH;
      end else if (flag) begin
        hold_reg_nx = instruction;
        hold_pc_nx = pc;
        ifid_valid_nx = 1'b0;
        state_nx = IMM;
      end else begin
        ifid_instruction_nx = instruction;
        ifid_immediate_nx = '0;
        ifid_pc_nx = pc;
        ifid_valid_nx = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      pc <= '0;
      hold_reg <= '0;
      hold_pc <= '0;
      ifid_instruction <= '0;
      ifid_immediate <= '0;
      ifid_pc <= '0;
      ifid_valid <= 1'b0;
      boot_done <= 1'b0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      hold_reg <= hold_reg_nx;
      hold_pc <= hold_pc_nx;
      ifid_instruction <= ifid_instruction_nx;
      ifid_immediate <= ifid_immediate_nx;
      ifid_pc <= ifid_pc_nx;
      ifid_valid <= ifid_valid_nx;
      boot_done <= boot_done_nx;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios against a 256-word instruction memory model
module tb_fetch_stage;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, redirect_en = 1'b0;
  logic [31:0] pc_address, instruction, redirect_pc = '0;
  logic [31:0] ifid_instruction, ifid_immediate, ifid_pc;
  logic ifid_valid, boot_done;
  logic [31:0] mem [256];
  int n_checks = 0, n_fail = 0;
  fetch_stage dut (
    .clk(clk), .rst(rst), .pc_address(pc_address), .instruction(instruction),
    .stall(stall), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .ifid_instruction(ifid_instruction), .ifid_immediate(ifid_immediate),
    .ifid_pc(ifid_pc), .ifid_valid(ifid_valid), .boot_done(boot_done)
  );
  always #5 clk = ~clk;
  assign instruction = mem[pc_address[7:0]];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    mem[8'h00] = 32'h0000_0010;
    rst = 1'b1;
    step();
    step();
    n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %h want 0", ifid_valid); end
    n_checks++; if (ifid_instruction !== 32'h0) begin n_fail++; $display("FAIL rst_instr got %h want 0", ifid_instruction); end
    n_checks++; if (ifid_immediate !== 32'h0) begin n_fail++; $display("FAIL rst_imm got %h want 0", ifid_immediate); end
    n_checks++; if (ifid_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h want 0", ifid_pc); end
    n_checks++; if (boot_done !== 1'b0) begin n_fail++; $display("FAIL rst_boot got %h want 0", boot_done); end
    n_checks++; if (pc_address !== 32'h0) begin n_fail++; $display("FAIL boot_addr got %h want 0", pc_address); end
    rst = 1'b0;
    step();
    n_checks++; if (boot_done !== 1'b1) begin n_fail++; $display("FAIL boot_done got %h want 1", boot_done); end
    n_checks++; if (pc_address !== 32'h10) begin n_fail++; $display("FAIL boot_vec got %h want 10", pc_address); end
    n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL boot_valid got %h want 0", ifid_valid); end
  endtask
  task automatic test_sequential();
    logic [31:0] w [3] = '{32'h111, 32'h222, 32'h333};
    for (int i = 0; i < 3; i++) mem[8'h10 + i] = w[i];
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (ifid_pc !== 32'h10 + i) begin n_fail++; $display("FAIL seq_pc[%0d] got %h want %h", i, ifid_pc, 32'h10 + i); end
      n_checks++; if (ifid_instruction !== w[i]) begin n_fail++; $display("FAIL seq_instr[%0d] got %h want %h", i, ifid_instruction, w[i]); end
      n_checks++; if (ifid_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d] got %h want 1", i, ifid_valid); end
      n_checks++; if (ifid_immediate !== 32'h0) begin n_fail++; $display("FAIL seq_imm[%0d] got %h want 0", i, ifid_immediate); end
    end
    n_checks++; if (pc_address !== 32'h13) begin n_fail++; $display("FAIL seq_next got %h want 13", pc_address); end
  endtask
  task automatic test_two_word();
    mem[8'h20] = 32'h0400_00AA;
    mem[8'h21] = 32'hDEAD_BEEF;
    redirect_en = 1'b1;
    redirect_pc = 32'h20;
    step();
    redirect_en = 1'b0;
    n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL rdr_valid got %h want 0", ifid_valid); end
    n_checks++; if (ifid_pc !== 32'h12) begin n_fail++; $display("FAIL rdr_keep_pc got %h want 12", ifid_pc); end
    n_checks++; if (pc_address !== 32'h20) begin n_fail++; $display("FAIL rdr_addr got %h want 20", pc_address); end
    step();
    n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL tw_bubble got %h want 0", ifid_valid); end
    n_checks++; if (pc_address !== 32'h21) begin n_fail++; $display("FAIL tw_addr1 got %h want 21", pc_address); end
    step();
    n_checks++; if (ifid_valid !== 1'b1) begin n_fail++; $display("FAIL tw_valid got %h want 1", ifid_valid); end
    n_checks++; if (ifid_instruction !== 32'h0400_00AA) begin n_fail++; $display("FAIL tw_instr got %h want 040000aa", ifid_instruction); end
    n_checks++; if (ifid_immediate !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL tw_imm got %h want deadbeef", ifid_immediate); end
    n_checks++; if (ifid_pc !== 32'h20) begin n_fail++; $display("FAIL tw_pc got %h want 20", ifid_pc); end
    n_checks++; if (pc_address !== 32'h22) begin n_fail++; $display("FAIL tw_next got %h want 22", pc_address); end
  endtask
  task automatic test_stall();
    mem[8'h22] = 32'h0400_0055;
    mem[8'h23] = 32'h1234_5678;
    mem[8'h24] = 32'h0000_0444;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (pc_address !== 32'h22) begin n_fail++; $display("FAIL stf_addr[%0d] got %h want 22", i, pc_address); end
      n_checks++; if (ifid_pc !== 32'h20 || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL stf_ifid[%0d] got %h/%h want 20/1", i, ifid_pc, ifid_valid); end
    end
    stall = 1'b0;
    step();
    n_checks++; if (ifid_valid !== 1'b0 || pc_address !== 32'h23) begin n_fail++; $display("FAIL sti_enter got %h/%h want 0/23", ifid_valid, pc_address); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (pc_address !== 32'h23 || ifid_valid !== 1'b0) begin n_fail++; $display("FAIL sti_hold[%0d] got %h/%h want 23/0", i, pc_address, ifid_valid); end
    end
    stall = 1'b0;
    step();
    n_checks++; if (ifid_instruction !== 32'h0400_0055 || ifid_immediate !== 32'h1234_5678) begin n_fail++; $display("FAIL st_tw got %h/%h want 04000055/12345678", ifid_instruction, ifid_immediate); end
    n_checks++; if (ifid_pc !== 32'h22 || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL st_tw_pc got %h/%h want 22/1", ifid_pc, ifid_valid); end
    step();
    n_checks++; if (ifid_instruction !== 32'h444 || ifid_pc !== 32'h24 || ifid_immediate !== 32'h0) begin n_fail++; $display("FAIL st_after got %h/%h/%h want 444/24/0", ifid_instruction, ifid_pc, ifid_immediate); end
  endtask
  task automatic test_redirect();
    mem[8'h25] = 32'h0400_0066;
    mem[8'h26] = 32'h0000_0777;
    mem[8'h40] = 32'h0000_0888;
    step();
    n_checks++; if (pc_address !== 32'h26 || ifid_valid !== 1'b0) begin n_fail++; $display("FAIL rd_imm got %h/%h want 26/0", pc_address, ifid_valid); end
    stall = 1'b1;
    redirect_en = 1'b1;
    redirect_pc = 32'h40;
    step();
    stall = 1'b0;
    redirect_en = 1'b0;
    n_checks++; if (pc_address !== 32'h40) begin n_fail++; $display("FAIL rd_addr got %h want 40", pc_address); end
    n_checks++; if (ifid_valid !== 1'b0 || ifid_pc !== 32'h24 || ifid_instruction !== 32'h444) begin n_fail++; $display("FAIL rd_keep got %h/%h/%h want 0/24/444", ifid_valid, ifid_pc, ifid_instruction); end
    step();
    n_checks++; if (ifid_instruction !== 32'h888 || ifid_pc !== 32'h40 || ifid_valid !== 1'b1 || ifid_immediate !== 32'h0) begin n_fail++; $display("FAIL rd_deliver got %h/%h/%h/%h want 888/40/1/0", ifid_instruction, ifid_pc, ifid_valid, ifid_immediate); end
  endtask
  task automatic test_wrap();
    mem[8'h00] = 32'hFFFF_FFFF;
    mem[8'hFF] = 32'h0000_0999;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    n_checks++; if (pc_address !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wr_boot got %h want ffffffff", pc_address); end
    step();
    n_checks++; if (ifid_pc !== 32'hFFFF_FFFF || ifid_instruction !== 32'h999 || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL wr_ifid got %h/%h/%h want ffffffff/999/1", ifid_pc, ifid_instruction, ifid_valid); end
    n_checks++; if (pc_address !== 32'h0) begin n_fail++; $display("FAIL wr_addr got %h want 0", pc_address); end
  endtask
  task automatic test_midop_reset();
    step();
    n_checks++; if (pc_address !== 32'h1 || ifid_valid !== 1'b0) begin n_fail++; $display("FAIL mr_imm got %h/%h want 1/0", pc_address, ifid_valid); end
    mem[8'h00] = 32'h0000_0050;
    mem[8'h01] = 32'h0000_0ABC;
    mem[8'h50] = 32'h0000_0001;
    rst = 1'b1;
    step();
    n_checks++; if (boot_done !== 1'b0 || ifid_instruction !== 32'h0 || ifid_pc !== 32'h0 || pc_address !== 32'h0) begin n_fail++; $display("FAIL mr_clear got %h/%h/%h/%h want 0/0/0/0", boot_done, ifid_instruction, ifid_pc, pc_address); end
    rst = 1'b0;
    step();
    n_checks++; if (boot_done !== 1'b1 || pc_address !== 32'h50) begin n_fail++; $display("FAIL mr_boot got %h/%h want 1/50", boot_done, pc_address); end
    step();
    n_checks++; if (ifid_instruction !== 32'h1 || ifid_immediate !== 32'h0 || ifid_pc !== 32'h50 || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL mr_fetch got %h/%h/%h/%h want 1/0/50/1", ifid_instruction, ifid_immediate, ifid_pc, ifid_valid); end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    #1;
    test_reset();
    test_sequential();
    test_two_word();
    test_stall();
    test_redirect();
    test_wrap();
    test_midop_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
